// File: rtl/age_issue_sel.sv
// age_issue_sel
//   Oldest-first multi-grant issue selector for the reservation station.
//   Each cycle it picks up to G of N requesting entries by wrap-aware age
//   (tag - head_tag), then pulses gnt for the picks. The picks are held in G
//   registered output slots, with a valid/ready handshake toward the FUs.
//
// Ports
//   clock, reset        : clock, async active-low reset
//   en, flush           : allow picks this cycle / squash all slots
//   req[N], tag[N]      : per-entry request and sequence tag
//   head_tag            : tag of oldest in-flight instruction (age origin)
//   gnt[N]              : combinational, entries picked this cycle
//   out_valid/idx/tag[G]: registered output slots
//   out_ready[G]        : FU accepts slot
module age_issue_sel #(
    parameter int N    = 16,
    parameter int G    = 2,
    parameter int TAGW = 6,
    parameter int IDXW = $clog2(N)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic [N-1:0]             req,
    input  logic [N-1:0][TAGW-1:0]   tag,
    input  logic [TAGW-1:0]          head_tag,
    output logic [N-1:0]             gnt,
    output logic [G-1:0]             out_valid,
    output logic [G-1:0][IDXW-1:0]   out_idx,
    output logic [G-1:0][TAGW-1:0]   out_tag,
    input  logic [G-1:0]             out_ready
);

    // Tree leaves are padded to a power of two; pad leaves are never valid.
    localparam int NP = 1 << IDXW;

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] age;
        logic [IDXW-1:0] idx;
    } cand_t;

    // Left operand always carries the lower index, so ties keep it.
    function automatic cand_t older(input cand_t a, input cand_t b);
        if (!b.vld)              return a;
        else if (!a.vld)         return b;
        else if (b.age < a.age)  return b;
        else                     return a;
    endfunction

    // Balanced min-tree over all entries in the mask.
    function automatic cand_t pick_oldest(input logic [N-1:0] m,
                                          input logic [N-1:0][TAGW-1:0] a);
        cand_t c [NP];
        for (int i = 0; i < NP; i++) begin
            c[i]     = '0;
            c[i].idx = i[IDXW-1:0];
        end
        for (int i = 0; i < N; i++) begin
            c[i].vld = m[i];
            c[i].age = a[i];
        end
        for (int s = 1; s < NP; s = s * 2) begin
            for (int i = 0; i < NP; i = i + 2 * s) begin
                c[i] = older(c[i], c[i+s]);
            end
        end
        return c[0];
    endfunction

    logic [G-1:0]            valid_q;
    logic [G-1:0][IDXW-1:0]  idx_q;
    logic [G-1:0][TAGW-1:0]  tag_q;

    logic [N-1:0][TAGW-1:0]  age;
    logic [N-1:0]            held;
    logic [G-1:0]            free;
    logic [G-1:0]            load;
    logic [G-1:0][IDXW-1:0]  ld_idx;
    logic [G-1:0][TAGW-1:0]  ld_tag;
    logic [N-1:0]            mask;
    cand_t                   c;

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_tag   = tag_q;

    // Modular subtraction makes ages wrap-aware around head_tag.
    always_comb begin
        age = '0;
        for (int i = 0; i < N; i++) age[i] = tag[i] - head_tag;
    end

    // Entries sitting in a stalled slot must not be picked again.
    always_comb begin
        held = '0;
        free = '0;
        for (int g = 0; g < G; g++) begin
            free[g] = !valid_q[g] || out_ready[g];
            for (int i = 0; i < N; i++) begin
                if (valid_q[g] && !out_ready[g] && idx_q[g] == i[IDXW-1:0])
                    held[i] = 1'b1;
            end
        end
    end

    // G sequential min-selections; each free slot in ascending order takes
    // the oldest remaining eligible entry, which is then removed from the mask.
    always_comb begin
        gnt    = '0;
        load   = '0;
        ld_idx = '0;
        ld_tag = '0;
        c      = '0;
        mask   = req & ~held;
        for (int g = 0; g < G; g++) begin
            if (free[g] && en && !flush) begin
                c = pick_oldest(mask, age);
                if (c.vld) begin
                    load[g]     = 1'b1;
                    ld_idx[g]   = c.idx;
                    ld_tag[g]   = tag[c.idx];
                    gnt[c.idx]  = 1'b1;
                    mask[c.idx] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int g = 0; g < G; g++) begin
                if (free[g]) begin
                    valid_q[g] <= load[g];
                    if (load[g]) begin
                        idx_q[g] <= ld_idx[g];
                        tag_q[g] <= ld_tag[g];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_age_issue_sel.sv
module tb_age_issue_sel;

    localparam int N = 16, G = 2, TAGW = 6, IDXW = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   en, flush;
    logic [N-1:0]           req;
    logic [N-1:0][TAGW-1:0] tag;
    logic [TAGW-1:0]        head_tag;
    logic [N-1:0]           gnt;
    logic [G-1:0]           out_valid;
    logic [G-1:0][IDXW-1:0] out_idx;
    logic [G-1:0][TAGW-1:0] out_tag;
    logic [G-1:0]           out_ready;

    int checks   = 0;
    int failures = 0;

    age_issue_sel #(.N(N), .G(G), .TAGW(TAGW)) dut (
        .clock(clock), .reset(reset), .en(en), .flush(flush),
        .req(req), .tag(tag), .head_tag(head_tag), .gnt(gnt),
        .out_valid(out_valid), .out_idx(out_idx), .out_tag(out_tag),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_slots(input string name, input logic [1:0] v,
                             input logic [3:0] i0, input logic [5:0] t0,
                             input logic [3:0] i1, input logic [5:0] t1);
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        chk({name, ".idx0"},  32'(out_idx[0]), 32'(i0));
        chk({name, ".tag0"},  32'(out_tag[0]), 32'(t0));
        chk({name, ".idx1"},  32'(out_idx[1]), 32'(i1));
        chk({name, ".tag1"},  32'(out_tag[1]), 32'(t1));
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; flush = 1'b0; req = '0; tag = '0;
        head_tag = '0; out_ready = '0;

        // Reset state and idle
        @(negedge clock); #1;
        chk_slots("reset", 2'b00, 4'd0, 6'd0, 4'd0, 6'd0);
        @(negedge clock);
        reset = 1'b1; en = 1'b1; out_ready = 2'b11;
        #1 chk("idle.gnt", 32'(gnt), 32'h0);
        @(negedge clock);
        chk("idle.valid", 32'(out_valid), 32'h0);

        // Oldest-first with wrap: ages 3->6, 7->2, 9->1
        head_tag = 6'd60;
        tag[3] = 6'd2; tag[7] = 6'd62; tag[9] = 6'd61;
        req = 16'h0288;
        #1 chk("wrap.gnt", 32'(gnt), 32'h0280);
        @(negedge clock);
        chk_slots("wrap.slots", 2'b11, 4'd9, 6'd61, 4'd7, 6'd62);

        // Async reset mid-cycle with slots valid
        req = '0; out_ready = 2'b00;
        #2 reset = 1'b0;
        #1 chk_slots("async_reset", 2'b00, 4'd0, 6'd0, 4'd0, 6'd0);
        @(negedge clock);
        reset = 1'b1;

        // Load slot0=idx1, slot1=idx2
        head_tag = 6'd0; tag = '0;
        tag[1] = 6'd10; tag[2] = 6'd20;
        req = 16'h0006; out_ready = 2'b11;
        #1 chk("load.gnt", 32'(gnt), 32'h0006);
        @(negedge clock);
        chk_slots("load.slots", 2'b11, 4'd1, 6'd10, 4'd2, 6'd20);

        // Both stalled: no picks, hold
        tag[4] = 6'd3; tag[5] = 6'd3;
        req = 16'h0030; out_ready = 2'b00;
        #1 chk("stall.gnt", 32'(gnt), 32'h0);
        @(negedge clock);
        chk_slots("stall.slots", 2'b11, 4'd1, 6'd10, 4'd2, 6'd20);

        // Only slot1 fires; entry1 (age 0) is held in stalled slot0, tie 4/5 -> 4
        tag[1] = 6'd0;
        req = 16'h0032; out_ready = 2'b10;
        #1 chk("tie.gnt", 32'(gnt), 32'h0010);
        @(negedge clock);
        chk_slots("tie.slots", 2'b11, 4'd1, 6'd10, 4'd4, 6'd3);

        // Backpressure hold for 5 cycles with all requesting
        for (int i = 0; i < N; i++) tag[i] = 6'(40 - 2 * i);
        req = 16'hFFFF; out_ready = 2'b00;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp.gnt", 32'(gnt), 32'h0);
            @(negedge clock);
            chk_slots("bp.slots", 2'b11, 4'd1, 6'd10, 4'd4, 6'd3);
        end
        out_ready = 2'b11;
        #1 chk("bp_release.gnt", 32'(gnt), 32'hC000);
        @(negedge clock);
        chk_slots("bp_release.slots", 2'b11, 4'd15, 6'd10, 4'd14, 6'd12);

        // Flush beats en and stalled handshake
        flush = 1'b1; req = 16'h00FF; out_ready = 2'b00;
        #1 chk("flush.gnt", 32'(gnt), 32'h0);
        @(negedge clock);
        chk("flush.valid", 32'(out_valid), 32'h0);
        flush = 1'b0;

        // Reload, then en gating
        out_ready = 2'b11;
        #1 chk("reload.gnt", 32'(gnt), 32'h00C0);
        @(negedge clock);
        chk_slots("reload.slots", 2'b11, 4'd7, 6'd26, 4'd6, 6'd28);
        en = 1'b0; req = 16'h003F;
        #1 chk("en0.gnt", 32'(gnt), 32'h0);
        @(negedge clock);
        chk("en0.valid", 32'(out_valid), 32'h0);
        en = 1'b1;
        #1 chk("en1.gnt", 32'(gnt), 32'h0030);
        @(negedge clock);
        chk_slots("en1.slots", 2'b11, 4'd5, 6'd30, 4'd4, 6'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
